// File: rtl/bus_arbiter.sv
// Shares one bus master port between instruction fetch (IF) and data access (MEM).
// MEM has priority; per-requester done flags block repeat accesses while the pipeline is held.
module bus_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_stallreq,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_stallreq,
  output logic        bus_cyc,
  output logic        bus_stb,
  output logic        bus_we,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, IF_BUSY, MEM_BUSY, FLUSH_WAIT} state_e;

  state_e      state_q;
  logic        if_done_q, mem_done_q;
  logic        bus_cyc_q, bus_we_q;
  logic [3:0]  bus_sel_q;
  logic [31:0] bus_addr_q, bus_wdata_q;
  logic [31:0] if_rdata_q, mem_rdata_q;

  logic unused_stall;
  assign unused_stall = ^{stall[5], stall[3:2], stall[0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
      bus_cyc_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_sel_q   <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      // Clears come first so a completing access below can re-set its flag.
      if (!stall[1] || flush) if_done_q  <= 1'b0;
      if (!stall[4] || flush) mem_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!flush) begin
            if (mem_req && !mem_done_q) begin
              state_q     <= MEM_BUSY;
              bus_cyc_q   <= 1'b1;
              bus_we_q    <= mem_we;
              bus_sel_q   <= mem_sel;
              bus_addr_q  <= mem_addr;
              bus_wdata_q <= mem_wdata;
            end else if (if_req && !if_done_q) begin
              state_q     <= IF_BUSY;
              bus_cyc_q   <= 1'b1;
              bus_we_q    <= 1'b0;
              bus_sel_q   <= '1;
              bus_addr_q  <= if_addr;
              bus_wdata_q <= '0;
            end
          end
        end
        IF_BUSY, MEM_BUSY, FLUSH_WAIT: begin
          if (bus_ack) begin
            state_q     <= IDLE;
            bus_cyc_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_sel_q   <= '0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            // A flush arriving together with the ack discards the data as well.
            if (!flush && state_q == IF_BUSY) begin
              if_rdata_q <= bus_rdata;
              if_done_q  <= 1'b1;
            end
            if (!flush && state_q == MEM_BUSY) begin
              if (!bus_we_q) mem_rdata_q <= bus_rdata;
              mem_done_q <= 1'b1;
            end
          end else if (flush) begin
            state_q <= FLUSH_WAIT;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_stallreq  = if_req  & ~if_done_q  & ~flush & ~rst;
  assign mem_stallreq = mem_req & ~mem_done_q & ~flush & ~rst;

  assign bus_cyc   = bus_cyc_q;
  assign bus_stb   = bus_cyc_q;
  assign bus_we    = bus_we_q;
  assign bus_sel   = bus_sel_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;

endmodule
